alu_rs_sched: RTL

- Reservation station and issue scheduler for the integer ALU in the Tomasulo core.
- Accepts decoded ALU/branch/JALR ops from the dispatcher and holds them until both operands are valid.
- Wakes entries by snooping the ALU and LSB CDB broadcasts.
- Sends one ready op per cycle to the combinational ALU through registered operand outputs.

---
 rtl/alu_rs_sched_pkg.sv | 19 +
 rtl/alu_rs_sched_select.sv | 36 +++
 rtl/alu_rs_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_sched_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings,
// ROB tag width and default depth.
// Build option: ALU_RS_AGE_ORDER_EN selects oldest-first issue instead of
// lowest-index-first.
package alu_rs_sched_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned RBID          = 4;
    localparam logic [31:0] NULL32        = '0;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC, OP_BEQ, OP_BNE, OP_BLT,
        OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR
    } alu_op_e;

endpackage

// File: rtl/alu_rs_sched_select.sv
// Request arbiter for the ALU reservation station: one-hot grant from a
// request vector. With ALU_RS_AGE_ORDER_EN the winner is the request with no
// older requester according to the supplied age matrix; otherwise the lowest
// index wins.
module rs_select
    import alu_rs_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic [DEPTH-1:0]            req,
`ifdef ALU_RS_AGE_ORDER_EN
    // older[i][j] = 1 means entry j is older than entry i
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic                        grant_valid
);

    // Pick exactly one requester
    always_comb begin
        grant = '0;
`ifdef ALU_RS_AGE_ORDER_EN
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && !(|(req & older[i]));
        end
`else
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
`endif
        grant_valid = |req;
    end

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station and issue scheduler. Holds decoded ALU/branch/JALR
// ops until both operands are available (snooping the ALU and LSB CDBs) and
// issues one ready op per cycle to the combinational ALU via registered
// outputs.
// Build option: ALU_RS_AGE_ORDER_EN -- oldest-ready issue through an age
// matrix; undefined gives lowest-index-ready issue.
module alu_rs_sched
    import alu_rs_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned ROB_W = RBID
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clr_in,
    input  logic             iss_valid_in,
    input  logic [5:0]       iss_op_in,
    input  logic [31:0]      iss_vj_in,
    input  logic             iss_qj_valid_in,
    input  logic [ROB_W-1:0] iss_qj_in,
    input  logic [31:0]      iss_vk_in,
    input  logic             iss_qk_valid_in,
    input  logic [ROB_W-1:0] iss_qk_in,
    input  logic [ROB_W-1:0] iss_rob_in,
    output logic             full_out,
    input  logic             cdb_alu_valid_in,
    input  logic [ROB_W-1:0] cdb_alu_rob_in,
    input  logic [31:0]      cdb_alu_val_in,
    input  logic             cdb_lsb_valid_in,
    input  logic [ROB_W-1:0] cdb_lsb_rob_in,
    input  logic [31:0]      cdb_lsb_val_in,
    output logic             alu_flag_out,
    output logic [5:0]       alu_op_out,
    output logic [31:0]      alu_val1_out,
    output logic [31:0]      alu_val2_out,
    output logic [ROB_W-1:0] alu_rob_out
);

    logic [DEPTH-1:0] busy, qj_v, qk_v, ready;
    logic [5:0]       op  [DEPTH];
    logic [31:0]      vj  [DEPTH];
    logic [31:0]      vk  [DEPTH];
    logic [ROB_W-1:0] qj  [DEPTH];
    logic [ROB_W-1:0] qk  [DEPTH];
    logic [ROB_W-1:0] rob [DEPTH];

    logic [DEPTH-1:0] wj_alu, wj_lsb, wk_alu, wk_lsb;
    logic [DEPTH-1:0] sel_gnt, free_gnt;
    logic             sel_valid, free_valid, do_ins;
    logic [31:0]      ins_vj, ins_vk;
    logic             ins_qj_v, ins_qk_v;
    logic [5:0]       d_op;
    logic [31:0]      d_vj, d_vk;
    logic [ROB_W-1:0] d_rob;

    assign ready    = busy & ~qj_v & ~qk_v;
    assign full_out = &busy;
    assign do_ins   = iss_valid_in && free_valid;

`ifdef ALU_RS_AGE_ORDER_EN
    logic [DEPTH-1:0][DEPTH-1:0] age;
    logic [DEPTH-1:0][DEPTH-1:0] low_first;

    // Static "lower index is older" matrix so the free-slot finder picks the lowest free slot
    always_comb begin
        low_first = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                low_first[i][j] = (j < i);
            end
        end
    end

    // Age matrix: a new row is younger than every busy entry; a freed entry's column is cleared
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            age <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                age <= '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (do_ins && free_gnt[i]) begin
                        age[i] <= busy;
                    end
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    for (int unsigned j = 0; j < DEPTH; j++) begin
                        if (sel_valid && sel_gnt[j]) begin
                            age[i][j] <= 1'b0;
                        end
                    end
                end
            end
        end
    end
`endif

    rs_select #(.DEPTH(DEPTH)) u_issue_sel (
        .req         (ready),
`ifdef ALU_RS_AGE_ORDER_EN
        .older       (age),
`endif
        .grant       (sel_gnt),
        .grant_valid (sel_valid)
    );

    rs_select #(.DEPTH(DEPTH)) u_free_sel (
        .req         (~busy),
`ifdef ALU_RS_AGE_ORDER_EN
        .older       (low_first),
`endif
        .grant       (free_gnt),
        .grant_valid (free_valid)
    );

    // Per-entry CDB tag matches for pending operands
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wj_alu[i] = busy[i] && qj_v[i] && cdb_alu_valid_in && (qj[i] == cdb_alu_rob_in);
            wj_lsb[i] = busy[i] && qj_v[i] && cdb_lsb_valid_in && (qj[i] == cdb_lsb_rob_in);
            wk_alu[i] = busy[i] && qk_v[i] && cdb_alu_valid_in && (qk[i] == cdb_alu_rob_in);
            wk_lsb[i] = busy[i] && qk_v[i] && cdb_lsb_valid_in && (qk[i] == cdb_lsb_rob_in);
        end
    end

    // Insert bypass: an operand whose producer broadcasts this cycle is captured directly (ALU first)
    always_comb begin
        ins_vj   = iss_vj_in;
        ins_qj_v = iss_qj_valid_in;
        if (iss_qj_valid_in && cdb_alu_valid_in && (iss_qj_in == cdb_alu_rob_in)) begin
            ins_vj   = cdb_alu_val_in;
            ins_qj_v = 1'b0;
        end else if (iss_qj_valid_in && cdb_lsb_valid_in && (iss_qj_in == cdb_lsb_rob_in)) begin
            ins_vj   = cdb_lsb_val_in;
            ins_qj_v = 1'b0;
        end
        ins_vk   = iss_vk_in;
        ins_qk_v = iss_qk_valid_in;
        if (iss_qk_valid_in && cdb_alu_valid_in && (iss_qk_in == cdb_alu_rob_in)) begin
            ins_vk   = cdb_alu_val_in;
            ins_qk_v = 1'b0;
        end else if (iss_qk_valid_in && cdb_lsb_valid_in && (iss_qk_in == cdb_lsb_rob_in)) begin
            ins_vk   = cdb_lsb_val_in;
            ins_qk_v = 1'b0;
        end
    end

    // Payload of the granted entry; all zero when nothing is granted
    always_comb begin
        d_op  = '0;
        d_vj  = NULL32;
        d_vk  = NULL32;
        d_rob = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_gnt[i]) begin
                d_op  = op[i];
                d_vj  = vj[i];
                d_vk  = vk[i];
                d_rob = rob[i];
            end
        end
    end

    // Control state and registered ALU outputs: flush > wakeup/dispatch/insert
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy         <= '0;
            qj_v         <= '0;
            qk_v         <= '0;
            alu_flag_out <= 1'b0;
            alu_op_out   <= '0;
            alu_val1_out <= NULL32;
            alu_val2_out <= NULL32;
            alu_rob_out  <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                busy         <= '0;
                qj_v         <= '0;
                qk_v         <= '0;
                alu_flag_out <= 1'b0;
                alu_op_out   <= '0;
                alu_val1_out <= NULL32;
                alu_val2_out <= NULL32;
                alu_rob_out  <= '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wj_alu[i] || wj_lsb[i]) qj_v[i] <= 1'b0;
                    if (wk_alu[i] || wk_lsb[i]) qk_v[i] <= 1'b0;
                    if (sel_valid && sel_gnt[i]) busy[i] <= 1'b0;
                    // free slot comes from registered busy, so it never collides with the dispatched one
                    if (do_ins && free_gnt[i]) begin
                        busy[i] <= 1'b1;
                        qj_v[i] <= ins_qj_v;
                        qk_v[i] <= ins_qk_v;
                    end
                end
                alu_flag_out <= sel_valid;
                alu_op_out   <= d_op;
                alu_val1_out <= d_vj;
                alu_val2_out <= d_vk;
                alu_rob_out  <= d_rob;
            end
        end
    end

    // Entry payload: operand capture on wakeup and field write on insert
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clr_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wj_alu[i])      vj[i] <= cdb_alu_val_in;
                else if (wj_lsb[i]) vj[i] <= cdb_lsb_val_in;
                if (wk_alu[i])      vk[i] <= cdb_alu_val_in;
                else if (wk_lsb[i]) vk[i] <= cdb_lsb_val_in;
                if (do_ins && free_gnt[i]) begin
                    op[i]  <= iss_op_in;
                    vj[i]  <= ins_vj;
                    qj[i]  <= iss_qj_in;
                    vk[i]  <= ins_vk;
                    qk[i]  <= iss_qk_in;
                    rob[i] <= iss_rob_in;
                end
            end
        end
    end

    // Inserting into a full station is a dispatcher protocol violation
    a_no_insert_when_full: assert property (
        @(posedge clk_in) disable iff (!rst_in)
        (rdy_in && iss_valid_in) |-> !full_out
    ) else $error("alu_rs_sched: iss_valid_in asserted while full_out");

endmodule
